// File: rtl/sig_monitor_ser.sv
// Multi-channel change monitor: latches the latest value per channel and serializes pending
// updates onto one valid/ready stream with round-robin arbitration and saturating drop count.
module sig_monitor_ser #(
    parameter int unsigned NUM_CH = 6,
    parameter int unsigned DW     = 32,
    parameter int unsigned CW     = $clog2(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH*DW-1:0] ch_data,
    input  logic [NUM_CH-1:0]    ch_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [CW-1:0]        out_ch,
    output logic [15:0]          drop_cnt
);

    logic [DW-1:0]     prev_q [NUM_CH];
    logic [DW-1:0]     val_q  [NUM_CH];
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic              out_valid_q;
    logic [DW-1:0]     out_data_q;
    logic [CW-1:0]     out_ch_q;
    logic [CW-1:0]     last_q;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    logic [NUM_CH-1:0] chg;
    logic              load;
    logic              gnt_vld;
    logic [CW-1:0]     gnt_idx;
    logic [DW-1:0]     gnt_val;
    logic [16:0]       drop_sum;
    int unsigned       ndrop;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            chg[i] = ch_en[i] && (ch_data[i*DW +: DW] != prev_q[i]);
        end
    end

    assign load = !out_valid_q || out_ready;

    // Scan downward so the last hit is the nearest pending channel after last_q.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        gnt_val = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            int unsigned idx;
            idx = (int'(last_q) + k) % NUM_CH;
            if (load && pending_q[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = CW'(idx);
                gnt_val = val_q[idx];
            end
        end
    end

    // A change on the channel being granted keeps it pending and is not a drop.
    always_comb begin
        pending_d = pending_q;
        ndrop     = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_vld && (gnt_idx == CW'(i))) begin
                pending_d[i] = 1'b0;
            end else if (chg[i] && pending_q[i]) begin
                ndrop = ndrop + 1;
            end
            if (chg[i]) begin
                pending_d[i] = 1'b1;
            end
        end
        drop_sum   = 17'(drop_cnt_q) + 17'(ndrop);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                prev_q[i] <= '0;
                val_q[i]  <= '0;
            end
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            last_q      <= CW'(NUM_CH - 1);
            drop_cnt_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                prev_q[i] <= ch_data[i*DW +: DW];
                if (chg[i]) begin
                    val_q[i] <= ch_data[i*DW +: DW];
                end
            end
            pending_q  <= pending_d;
            drop_cnt_q <= drop_cnt_d;
            if (load) begin
                if (gnt_vld) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= gnt_val;
                    out_ch_q    <= gnt_idx;
                    last_q      <= gnt_idx;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
